mvm_rx_arbiter: RTL

- Shares one MVM chain (two cascaded rtl_mvm stages) between NREQ independent AXI-Stream requesters.
- Arbitration is round-robin and packet-granular. Once a requester is granted, it keeps the grant until the beat carrying tlast is accepted.
- Sits directly in front of the chain's axis_rx_* port.
- Output is registered through a 2-entry buffer, so the arbiter never feeds combinational ready into the MVM.

---
 rtl/mvm_arb_pkg.sv | 50 +++++
 rtl/axis_skid_buffer.sv | 80 ++++++++
 rtl/mvm_rx_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mvm_arb_pkg.sv
// Shared types and helpers for the MVM receive-side arbiter: FSM state,
// the AXI-Stream beat record and the round-robin pick function.
package mvm_arb_pkg;

   localparam int DATAW   = 128;
   localparam int BYTEW   = 8;
   localparam int IDW     = 32;
   localparam int DESTW   = 12;
   localparam int USERW   = 75;
   localparam int MAXREQ  = 16;
   localparam int MAXREQW = 4;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [BYTEW-1:0] strb;
      logic [BYTEW-1:0] keep;
      logic             last;
      logic [IDW-1:0]   id;
      logic [DESTW-1:0] dest;
      logic [USERW-1:0] user;
   } beat_t;

   // Returns the first asserted index in valid, scanning lastPtr+1,
   // lastPtr+2, ... modulo nreq. Returns lastPtr when nothing is valid.
   function automatic logic [MAXREQW-1:0] rr_pick(
      input logic [MAXREQ-1:0]  valid,
      input logic [MAXREQW-1:0] lastPtr,
      input int                 nreq
   );
      logic [MAXREQW-1:0] pick;
      logic               found;
      int                 idx;
      pick  = lastPtr;
      found = 1'b0;
      for (int k = 1; k <= MAXREQ; k++) begin
         idx = int'(lastPtr) + k;
         if (idx >= nreq) begin
            idx = idx - nreq;
         end
         if (!found && (k <= nreq) && valid[idx[MAXREQW-1:0]]) begin
            pick  = idx[MAXREQW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered FIFO for whole AXI-Stream beats. in_ready depends only
// on the occupancy register, so no combinational ready path crosses it, and a
// simultaneous push and pop keeps one beat per cycle flowing.
module axis_skid_buffer
   import mvm_arb_pkg::*;
#(
   parameter type T = beat_t
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic [1:0] countQ, countD;
   T           headQ, headD;
   T           spillQ, spillD;
   logic       push;
   logic       pop;

   assign in_ready  = (countQ != 2'd2);
   assign out_valid = (countQ != 2'd0);
   assign out_data  = headQ;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next occupancy and entry contents; head is always the oldest beat.
   always_comb begin
      countD = countQ;
      headD  = headQ;
      spillD = spillQ;
      case (countQ)
         2'd0: begin
            if (push) begin
               headD  = in_data;
               countD = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               headD = in_data;
            end else if (push) begin
               spillD = in_data;
               countD = 2'd2;
            end else if (pop) begin
               countD = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               headD  = spillQ;
               countD = 2'd1;
            end
         end
         default: begin
            countD = 2'd0;
         end
      endcase
   end

   // Occupancy register; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         countQ <= 2'd0;
      end else begin
         countQ <= countD;
      end
   end

   // Entry storage; contents are meaningless while the count says empty.
   always_ff @(posedge clk) begin
      headQ  <= headD;
      spillQ <= spillD;
   end

endmodule

// File: rtl/mvm_rx_arbiter.sv
// Packet-granular round-robin arbiter sharing one MVM chain input among NREQ
// AXI-Stream requesters. A grant is held until the granted lane's tlast beat
// is accepted; each new grant costs one idle cycle. Beats leave through a
// two-entry registered buffer.
module mvm_rx_arbiter
   import mvm_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NREQW = $clog2(NREQ),
   parameter int DATAW = 128,
   parameter int BYTEW = 8,
   parameter int IDW   = 32,
   parameter int DESTW = 12,
   parameter int USERW = 75
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic [NREQ-1:0]        axis_rx_tvalid,
   output logic [NREQ-1:0]        axis_rx_tready,
   input  logic [NREQ*DATAW-1:0]  axis_rx_tdata,
   input  logic [NREQ*BYTEW-1:0]  axis_rx_tstrb,
   input  logic [NREQ*BYTEW-1:0]  axis_rx_tkeep,
   input  logic [NREQ-1:0]        axis_rx_tlast,
   input  logic [NREQ*IDW-1:0]    axis_rx_tid,
   input  logic [NREQ*DESTW-1:0]  axis_rx_tdest,
   input  logic [NREQ*USERW-1:0]  axis_rx_tuser,

   output logic                   axis_tx_tvalid,
   input  logic                   axis_tx_tready,
   output logic [DATAW-1:0]       axis_tx_tdata,
   output logic [BYTEW-1:0]       axis_tx_tstrb,
   output logic [BYTEW-1:0]       axis_tx_tkeep,
   output logic                   axis_tx_tlast,
   output logic [IDW-1:0]         axis_tx_tid,
   output logic [DESTW-1:0]       axis_tx_tdest,
   output logic [USERW-1:0]       axis_tx_tuser,

   output logic [NREQW-1:0]       grant_idx,
   output logic                   busy
);

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [BYTEW-1:0] strb;
      logic [BYTEW-1:0] keep;
      logic             last;
      logic [IDW-1:0]   id;
      logic [DESTW-1:0] dest;
      logic [USERW-1:0] user;
   } rx_beat_t;

   arb_state_t       stateQ, stateD;
   logic [NREQW-1:0] grantQ, grantD;
   logic [NREQW-1:0] lastPtrQ, lastPtrD;

   rx_beat_t         selBeat;
   rx_beat_t         outBeat;
   logic             laneValid;
   logic             pushValid;
   logic             bufReady;
   logic             accept;

   // Gather the granted lane's beat and valid from the packed input buses.
   always_comb begin
      selBeat   = '0;
      laneValid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantQ == NREQW'(i)) begin
            laneValid    = axis_rx_tvalid[i];
            selBeat.data = axis_rx_tdata[i*DATAW +: DATAW];
            selBeat.strb = axis_rx_tstrb[i*BYTEW +: BYTEW];
            selBeat.keep = axis_rx_tkeep[i*BYTEW +: BYTEW];
            selBeat.last = axis_rx_tlast[i];
            selBeat.id   = axis_rx_tid[i*IDW +: IDW];
            selBeat.dest = axis_rx_tdest[i*DESTW +: DESTW];
            selBeat.user = axis_rx_tuser[i*USERW +: USERW];
         end
      end
   end

   assign pushValid = (stateQ == LOCKED) && laneValid;
   assign accept    = pushValid && bufReady;

   // Arbitration state, current grant and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= IDLE;
         grantQ   <= '0;
         lastPtrQ <= NREQW'(NREQ - 1);
      end else begin
         stateQ   <= stateD;
         grantQ   <= grantD;
         lastPtrQ <= lastPtrD;
      end
   end

   // Pick a lane when idle; release it once its tlast beat is taken.
   always_comb begin
      stateD   = stateQ;
      grantD   = grantQ;
      lastPtrD = lastPtrQ;
      case (stateQ)
         IDLE: begin
            if (|axis_rx_tvalid) begin
               grantD = NREQW'(rr_pick(MAXREQ'(axis_rx_tvalid),
                                       MAXREQW'(lastPtrQ), NREQ));
               stateD = LOCKED;
            end
         end
         LOCKED: begin
            if (accept && selBeat.last) begin
               lastPtrD = grantQ;
               stateD   = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // Only the granted lane sees ready, and only while the buffer has room.
   always_comb begin
      axis_rx_tready = '0;
      if (stateQ == LOCKED) begin
         axis_rx_tready[grantQ] = bufReady;
      end
      busy      = (stateQ == LOCKED);
      grant_idx = grantQ;
   end

   axis_skid_buffer #(
      .T (rx_beat_t)
   ) u_outBuf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pushValid),
      .in_ready  (bufReady),
      .in_data   (selBeat),
      .out_valid (axis_tx_tvalid),
      .out_ready (axis_tx_tready),
      .out_data  (outBeat)
   );

   assign axis_tx_tdata = outBeat.data;
   assign axis_tx_tstrb = outBeat.strb;
   assign axis_tx_tkeep = outBeat.keep;
   assign axis_tx_tlast = outBeat.last;
   assign axis_tx_tid   = outBeat.id;
   assign axis_tx_tdest = outBeat.dest;
   assign axis_tx_tuser = outBeat.user;

endmodule
